// File: rtl/darkbtn_pkg.sv
// darkbtn_pkg: register map and ID word shared by the darkbtn input peripheral.
`default_nettype none

package darkbtn_pkg;

  typedef enum logic [1:0] {
    BTN_ADDR_LEVEL = 2'd0,
    BTN_ADDR_EVENT = 2'd1,
    BTN_ADDR_RAW   = 2'd2,
    BTN_ADDR_ID    = 2'd3
  } btn_addr_e;

  localparam logic [7:0] BTN_ID_MAGIC   = 8'hB7;
  localparam logic [7:0] BTN_ID_VERSION = 8'h01;

  // ID word: {8'hB7, N[3:0], 4'h0, N[7:0], version}; never zero because of the magic byte.
  function automatic logic [31:0] btn_id(input int n);
    logic [31:0] nv;
    nv = n;
    return {BTN_ID_MAGIC, nv[3:0], 4'h0, nv[7:0], BTN_ID_VERSION};
  endfunction

endpackage

`default_nettype wire

// File: rtl/darkbtn_debounce.sv
// darkbtn_debounce: one input channel -- 2-flop synchronizer, debounce counter,
// committed stable level and one-cycle rise/fall pulses coincident with the commit edge.
`default_nettype none

module darkbtn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic sync,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_commit;

  assign w_differ = r_sync ^ r_stable;
  assign w_commit = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= btn;
      r_sync <= r_meta;
      // Any return to the stable value restarts the qualification window.
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_commit) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sync   = r_sync;
  assign stable = r_stable;
  assign rise   = w_commit &  r_sync;
  assign fall   = w_commit & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/darkbtn.sv
// darkbtn: debounced button/switch peripheral with sticky event flags and a one-cycle read ack.
// Optional DARKBTN_IRQ_EN adds a registered irq output asserted while any event flag is set.
`default_nettype none

module darkbtn
  import darkbtn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic [N_BTN-1:0] btn,
  input  logic             rd,
  input  logic [1:0]       addr,
  output logic [31:0]      rdata,
  output logic             ack
`ifdef DARKBTN_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [31:0] C_ID_WORD = btn_id(N_BTN);

  logic [N_BTN-1:0] w_sync;
  logic [N_BTN-1:0] w_stable;
  logic [N_BTN-1:0] w_rise_set;
  logic [N_BTN-1:0] w_fall_set;
  logic [N_BTN-1:0] r_rise;
  logic [N_BTN-1:0] r_fall;
  logic             w_evt_clr;
  logic [31:0]      w_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      darkbtn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (XCLK),
        .rst   (XRES),
        .btn   (btn[gi]),
        .sync  (w_sync[gi]),
        .stable(w_stable[gi]),
        .rise  (w_rise_set[gi]),
        .fall  (w_fall_set[gi])
      );
    end
  endgenerate

  assign w_evt_clr = rd && (addr == BTN_ADDR_EVENT);

  // Clear-on-read drops the returned flags, but a set on the same edge wins.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_rise_set | (w_evt_clr ? '0 : r_rise);
      r_fall <= w_fall_set | (w_evt_clr ? '0 : r_fall);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (btn_addr_e'(addr))
      BTN_ADDR_LEVEL: w_rdata[N_BTN-1:0] = w_stable;
      BTN_ADDR_EVENT: begin
        w_rdata[N_BTN-1:0]  = r_rise;
        w_rdata[8 +: N_BTN] = r_fall;
      end
      BTN_ADDR_RAW:   w_rdata[N_BTN-1:0] = w_sync;
      BTN_ADDR_ID:    w_rdata = C_ID_WORD;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      rdata <= '0;
      ack   <= 1'b0;
    end else begin
      rdata <= rd ? w_rdata : '0;
      ack   <= rd;
    end
  end

`ifdef DARKBTN_IRQ_EN
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      irq <= 1'b0;
    end else begin
      irq <= |{r_rise, r_fall};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_darkbtn.sv
// tb_darkbtn: directed self-checking bench for darkbtn with N_BTN=4, DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_darkbtn;

  localparam logic [31:0] ID_WORD = 32'hB740_0401;

  logic        XCLK;
  logic        XRES;
  logic [3:0]  btn;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] rdata;
  logic        ack;
`ifdef DARKBTN_IRQ_EN
  logic        irq;
`endif

  int vectors;
  int miscompares;

  darkbtn #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .XCLK (XCLK),
    .XRES (XRES),
    .btn  (btn),
    .rd   (rd),
    .addr (addr),
    .rdata(rdata),
    .ack  (ack)
`ifdef DARKBTN_IRQ_EN
    ,
    .irq  (irq)
`endif
  );

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold rd high across one edge with the given address; checks the ack cycle.
  task automatic rd_step(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd   = 1'b1;
    addr = a;
    tick();
    check($sformatf("%s.ack", tag), {31'b0, ack}, 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic idle_check(input string tag);
    rd = 1'b0;
    tick();
    check($sformatf("%s.ack", tag), {31'b0, ack}, 32'd0);
    check($sformatf("%s.rdata", tag), rdata, 32'd0);
  endtask

  task automatic irq_check(input string tag, input logic exp);
`ifdef DARKBTN_IRQ_EN
    check(tag, {31'b0, irq}, {31'b0, exp});
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    XRES = 1'b1;
    btn  = 4'b0000;
    rd   = 1'b0;
    addr = 2'd0;

    // Reset state
    ticks(3);
    check("reset.ack", {31'b0, ack}, 32'd0);
    check("reset.rdata", rdata, 32'd0);
    irq_check("reset.irq", 1'b0);
    XRES = 1'b0;
    idle_check("post_reset");

    // ID register, single-cycle ack
    rd_step(2'd3, ID_WORD, "id");
    idle_check("id_end");

    // btn[0] press: stable commits on the 6th edge after the change
    btn[0] = 1'b1;
    ticks(5);
    rd_step(2'd0, 32'h0, "lvl_edge6");
    irq_check("irq_before_rise0", 1'b0);
    rd_step(2'd0, 32'h1, "lvl_edge7");
    irq_check("irq_after_rise0", 1'b1);
    rd_step(2'd1, 32'h1, "evt_rise0");
    rd_step(2'd1, 32'h0, "evt_cleared");
    irq_check("irq_dropped", 1'b0);
    idle_check("b2b_end");

    // btn[1] 3-cycle glitch: visible on raw only, two edges late
    btn[1] = 1'b1;
    rd_step(2'd2, 32'h1, "raw_e1");
    rd_step(2'd2, 32'h1, "raw_e2");
    rd_step(2'd2, 32'h3, "raw_e3");
    btn[1] = 1'b0;
    rd_step(2'd2, 32'h3, "raw_e4");
    rd_step(2'd2, 32'h3, "raw_e5");
    rd_step(2'd2, 32'h1, "raw_e6");
    rd_step(2'd0, 32'h1, "glitch_lvl");
    rd_step(2'd1, 32'h0, "glitch_evt");
    idle_check("glitch_end");

    // btn[2] press then release, 10 cycles each
    btn[2] = 1'b1;
    ticks(10);
    btn[2] = 1'b0;
    ticks(10);
    rd_step(2'd1, 32'h0000_0404, "press_release");
    rd_step(2'd0, 32'h1, "press_release_lvl");
    idle_check("pr_end");

    // Read on the same edge rise[3] sets: set wins, returned bit is pre-edge
    btn[3] = 1'b1;
    ticks(5);
    rd_step(2'd1, 32'h0, "race_first");
    irq_check("irq_race_first", 1'b0);
    rd_step(2'd1, 32'h8, "race_second");
    irq_check("irq_race_second", 1'b1);
    idle_check("race_end");
    irq_check("irq_race_end", 1'b0);

    // Release everything and collect falls
    btn = 4'b0000;
    ticks(10);
    rd_step(2'd1, 32'h0000_0900, "falls");
    idle_check("falls_end");

    // Reset mid-debounce of btn[0]
    btn[0] = 1'b1;
    ticks(4);
    rd_step(2'd3, ID_WORD, "pre_reset_id");
    XRES = 1'b1;
    #1;
    check("async_reset.ack", {31'b0, ack}, 32'd0);
    check("async_reset.rdata", rdata, 32'd0);
    rd = 1'b0;
    tick();
    XRES = 1'b0;
    ticks(4);
    rd_step(2'd0, 32'h0, "rst_lvl_e5");
    rd_step(2'd1, 32'h0, "rst_evt_e6");
    rd_step(2'd1, 32'h1, "rst_evt_e7");
    irq_check("irq_rst_rise", 1'b1);
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
